q_loop_sequencer: RTL and testbench

Sequences the charge-regulation loop: issues measurement requests to q_measurement, waits for ready, then grants one enable step to the bisection controller. After each step it waits a settling interval before the next measurement. It declares lock after LOCK_COUNT consecutive in-tolerance measurements and faults on a measurement watchdog timeout. It sits in top between q_measurement and bisection and replaces the free-running start/enable inputs.

---
 rtl/q_loop_sequencer_if.sv | 25 ++
 rtl/q_loop_sequencer.sv | 139 +++++++++++++
 tb/tb_q_loop_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_loop_sequencer_if.sv
// q_loop_sequencer_if: run/measurement/step handshake bundle between the
// loop sequencer (master) and its environment (slave).
interface q_loop_sequencer_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 run;
  logic [BUS_WIDTH-1:0] q_desired;
  logic                 ready;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 start;
  logic                 enable;
  logic                 locked;
  logic                 fault;
  logic                 busy;

  modport master (
    input  run, q_desired, ready, q_measured,
    output start, enable, locked, fault, busy
  );

  modport slave (
    output run, q_desired, ready, q_measured,
    input  start, enable, locked, fault, busy
  );
endinterface

// File: rtl/q_loop_sequencer.sv
// q_loop_sequencer: paces the charge-regulation loop. Requests a measurement,
// waits for ready, grants one bisection step when out of tolerance, settles,
// repeats. Locks after LOCK_COUNT consecutive in-tolerance results; faults on
// a measurement watchdog timeout.
// Optional: define QLOOP_RELOCK_EN to keep measuring while LOCKED and resume
// regulation when the loop drifts out of tolerance.
module q_loop_sequencer #(
  parameter int BUS_WIDTH      = 10,
  parameter int TOL            = 1,
  parameter int LOCK_COUNT     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_WIDTH      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  q_loop_sequencer_if.master    bus
);
  localparam int LCW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_STEP, S_SETTLE, S_LOCKED, S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;     // shared settle / watchdog counter
  logic [LCW-1:0]       lcnt_q, lcnt_d;   // consecutive in-tolerance count
  logic                 locked_q, locked_d;
  logic                 run_q;            // run delayed one cycle for IDLE exit

  // Signed error at BUS_WIDTH+1 bits so extreme codes never wrap.
  logic [BUS_WIDTH:0] diff, mag;
  logic               in_tol;

  assign diff   = {1'b0, bus.q_measured} - {1'b0, bus.q_desired};
  assign mag    = diff[BUS_WIDTH] ? (~diff + (BUS_WIDTH+1)'(1)) : diff;
  assign in_tol = (mag <= (BUS_WIDTH+1)'(TOL));

  // State and counter registers; reset aborts any sequence at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lcnt_q   <= '0;
      locked_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
      run_q    <= bus.run;
    end
  end

  // Next-state logic; dropping run overrides every state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lcnt_d   = lcnt_q;
    locked_d = locked_q;
    if (!bus.run) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      lcnt_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (run_q) state_d = S_REQ;
        S_REQ: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          // cnt_q == 0 is the first WAIT cycle: ready may be left over from
          // the previous measurement, so it is not trusted yet.
          if (cnt_q != '0 && bus.ready) begin
            cnt_d = '0;
            if (in_tol) begin
              if (locked_q) begin
                state_d = S_LOCKED;
              end else if (lcnt_q == LCW'(LOCK_COUNT - 1)) begin
                lcnt_d   = LCW'(LOCK_COUNT);
                locked_d = 1'b1;
                state_d  = S_LOCKED;
              end else begin
                lcnt_d  = lcnt_q + LCW'(1);
                state_d = S_SETTLE;
              end
            end else begin
              lcnt_d   = '0;
              locked_d = 1'b0;
              state_d  = S_STEP;
            end
          end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            lcnt_d   = '0;
            locked_d = 1'b0;
            state_d  = S_FAULT;
          end
        end
        S_STEP: begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        S_LOCKED: begin
`ifdef QLOOP_RELOCK_EN
          // Monitoring: re-measure every SETTLE_CYCLES while locked_q holds.
          if (cnt_q == CNT_WIDTH'(SETTLE_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
`else
          state_d = S_LOCKED;
`endif
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pulses are gated by run so a pulse due in the cycle run falls is dropped.
  assign bus.start  = (state_q == S_REQ)  && bus.run;
  assign bus.enable = (state_q == S_STEP) && bus.run;
  assign bus.locked = locked_q;
  assign bus.fault  = (state_q == S_FAULT);
  assign bus.busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_q_loop_sequencer.sv
// tb_q_loop_sequencer: directed scenarios for q_loop_sequencer with
// hand-computed cycle timing (SETTLE=8, TIMEOUT=1023, LOCK_COUNT=4, TOL=1).
module tb_q_loop_sequencer;
  localparam int BW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q_loop_sequencer_if #(.BUS_WIDTH(BW)) bus ();

  q_loop_sequencer #(
    .BUS_WIDTH(BW), .TOL(1), .LOCK_COUNT(4), .SETTLE_CYCLES(8),
    .TIMEOUT_CYCLES(1023), .CNT_WIDTH(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int st_cnt = 0;
  int en_cnt = 0;
  int both_cnt = 0;

  // Observe pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.start)  st_cnt++;
    if (bus.enable) en_cnt++;
    if (bus.start && bus.enable) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until start is seen; n = cycles stepped.
  task automatic wait_start(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.start) begin
        ok = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  // Called in the start cycle: ready rises 5 cycles later, en is the
  // enable observed in the following cycle.
  task automatic meas(input logic [BW-1:0] v, output bit en);
    repeat (5) step();
    bus.ready      = 1'b1;
    bus.q_measured = v;
    step();
    en        = bus.enable;
    bus.ready = 1'b0;
  endtask

  task automatic restart();
    bus.run   = 1'b0;
    bus.ready = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.run = 1'b0; bus.ready = 1'b0;
    bus.q_desired = '0; bus.q_measured = '0;
    #3;
    checks++;
    if ({bus.start, bus.enable, bus.locked, bus.fault, bus.busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {bus.start, bus.enable, bus.locked, bus.fault, bus.busy});
    end
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int n; bit ok, en; int e0;
    restart();
    bus.q_desired = 10'd500;
    e0 = en_cnt;
    bus.run = 1'b1;
    wait_start(n, ok);
    checks++;
    if (!ok || n != 2) begin
      errors++; $display("FAIL basic_start_latency: got %0d ok %0d want 2", n, ok);
    end
    meas(10'd300, en);
    checks++;
    if (en !== 1'b1) begin
      errors++; $display("FAIL basic_enable: got %b want 1", en);
    end
    wait_start(n, ok);
    checks++;
    if (!ok || n != 9) begin
      errors++; $display("FAIL basic_settle: got %0d want 9", n);
    end
    checks++;
    if (bus.locked !== 1'b0 || en_cnt - e0 != 1) begin
      errors++; $display("FAIL basic_locked_en: locked %b en %0d want 0 1",
                         bus.locked, en_cnt - e0);
    end
  endtask

  task automatic test_lock();
    logic [BW-1:0] vals [4] = '{10'd499, 10'd501, 10'd500, 10'd500};
    int n; bit ok, en; int e0, s0;
    restart();
    bus.q_desired = 10'd500;
    e0 = en_cnt;
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL lock_start%0d: no start", i); end
      meas(vals[i], en);
      checks++;
      if (bus.locked !== (i == 3)) begin
        errors++; $display("FAIL lock_flag%0d: got %b want %b", i, bus.locked, i == 3);
      end
    end
    checks++;
    if (en_cnt - e0 != 0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL lock_no_enable: en %0d busy %b want 0 1", en_cnt - e0, bus.busy);
    end
`ifndef QLOOP_RELOCK_EN
    s0 = st_cnt;
    repeat (40) step();
    checks++;
    if (st_cnt != s0 || bus.locked !== 1'b1) begin
      errors++; $display("FAIL lock_terminal: starts %0d locked %b want 0 1", st_cnt - s0, bus.locked);
    end
`else
    s0 = st_cnt;
`endif
  endtask

  task automatic test_lock_reset();
    logic [BW-1:0] vals [7] = '{10'd500, 10'd500, 10'd510, 10'd500,
                                10'd500, 10'd500, 10'd500};
    int n; bit ok, en; int e0;
    restart();
    bus.q_desired = 10'd500;
    e0 = en_cnt;
    bus.run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_start(n, ok);
      meas(vals[i], en);
      checks++;
      if (en !== (i == 2)) begin
        errors++; $display("FAIL lrst_enable%0d: got %b want %b", i, en, i == 2);
      end
      checks++;
      if (bus.locked !== (i == 6)) begin
        errors++; $display("FAIL lrst_locked%0d: got %b want %b", i, bus.locked, i == 6);
      end
    end
    checks++;
    if (en_cnt - e0 != 1) begin
      errors++; $display("FAIL lrst_enable_count: got %0d want 1", en_cnt - e0);
    end
  endtask

  task automatic test_error_boundary();
    int n; bit ok, en;
    restart();
    bus.q_desired = 10'd0;
    bus.run = 1'b1;
    wait_start(n, ok);
    meas(10'd1023, en);
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL err_nowrap: got %b want 1", en); end
    bus.q_desired = 10'd1023;
    wait_start(n, ok);
    meas(10'd1022, en);
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL err_tol_edge: got %b want 0", en); end
    wait_start(n, ok);
    meas(10'd1021, en);
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL err_tol_over: got %b want 1", en); end
  endtask

  task automatic test_stale_ready();
    int n; bit ok; int e0;
    restart();
    bus.q_desired = 10'd500;
    bus.run = 1'b1;
    wait_start(n, ok);
    e0 = en_cnt;
    bus.ready = 1'b1; bus.q_measured = 10'd300;
    step(); step();
    bus.ready = 1'b0;
    repeat (3) step();
    checks++;
    if (en_cnt - e0 != 0) begin
      errors++; $display("FAIL stale_ready: enables %0d want 0", en_cnt - e0);
    end
    bus.ready = 1'b1;
    step();
    checks++;
    if (bus.enable !== 1'b1) begin
      errors++; $display("FAIL stale_then_real: got %b want 1", bus.enable);
    end
    bus.ready = 1'b0;
  endtask

  task automatic test_abort();
    int n; bit ok, en; int s0, e0;
    restart();
    bus.q_desired = 10'd500;
    bus.run = 1'b1;
    wait_start(n, ok);
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.start !== 1'b0) begin errors++; $display("FAIL abort_req_start: got %b want 0", bus.start); end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_req_idle: got %b want 0", bus.busy); end
    bus.run = 1'b1;
    wait_start(n, ok);
    checks++;
    if (!ok || n != 2) begin errors++; $display("FAIL abort_restart: got %0d want 2", n); end
    meas(10'd300, en);
    repeat (3) step();
    bus.run = 1'b0;
    s0 = st_cnt; e0 = en_cnt;
    step();
    repeat (20) step();
    checks++;
    if (bus.busy !== 1'b0 || st_cnt != s0 || en_cnt != e0) begin
      errors++; $display("FAIL abort_settle: busy %b starts %0d enables %0d want 0 0 0",
                         bus.busy, st_cnt - s0, en_cnt - e0);
    end
    bus.run = 1'b1;
    wait_start(n, ok);
    step(); step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.start, bus.enable, bus.locked, bus.fault, bus.busy} !== 5'b0) begin
      errors++; $display("FAIL abort_async_rst: got %b want 00000",
                         {bus.start, bus.enable, bus.locked, bus.fault, bus.busy});
    end
    bus.run = 1'b0;
    step();
    rst = 1'b0;
    s0 = st_cnt; e0 = en_cnt;
    repeat (20) step();
    checks++;
    if (st_cnt != s0 || en_cnt != e0) begin
      errors++; $display("FAIL abort_quiet: starts %0d enables %0d want 0 0", st_cnt - s0, en_cnt - e0);
    end
  endtask

  task automatic test_watchdog();
    int n; bit ok; int e0, s0;
    restart();
    bus.q_desired = 10'd500;
    bus.run = 1'b1;
    wait_start(n, ok);
    e0 = en_cnt;
    repeat (1023) step();
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL wd_early: got %b want 0", bus.fault); end
    step();
    checks++;
    if (bus.fault !== 1'b1 || bus.locked !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL wd_fault: fault %b locked %b busy %b want 1 0 1",
                         bus.fault, bus.locked, bus.busy);
    end
    s0 = st_cnt;
    repeat (20) step();
    checks++;
    if (st_cnt != s0 || en_cnt != e0 || bus.fault !== 1'b1) begin
      errors++; $display("FAIL wd_sticky: starts %0d enables %0d fault %b want 0 0 1",
                         st_cnt - s0, en_cnt - e0, bus.fault);
    end
    bus.run = 1'b0;
    step();
    checks++;
    if (bus.fault !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL wd_clear: fault %b busy %b want 0 0", bus.fault, bus.busy);
    end
    bus.run = 1'b1;
    wait_start(n, ok);
    checks++;
    if (!ok || n != 2) begin errors++; $display("FAIL wd_fresh_start: got %0d want 2", n); end
  endtask

`ifdef QLOOP_RELOCK_EN
  task automatic test_relock();
    int n; bit ok, en;
    restart();
    bus.q_desired = 10'd500;
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(n, ok);
      meas(10'd500, en);
    end
    wait_start(n, ok);
    checks++;
    if (!ok || n != 8) begin errors++; $display("FAIL relock_monitor: got %0d want 8", n); end
    meas(10'd500, en);
    checks++;
    if (en !== 1'b0 || bus.locked !== 1'b1) begin
      errors++; $display("FAIL relock_hold: en %b locked %b want 0 1", en, bus.locked);
    end
    wait_start(n, ok);
    meas(10'd520, en);
    checks++;
    if (en !== 1'b1 || bus.locked !== 1'b0) begin
      errors++; $display("FAIL relock_drop: en %b locked %b want 1 0", en, bus.locked);
    end
    wait_start(n, ok);
    checks++;
    if (!ok || n != 9) begin errors++; $display("FAIL relock_resume: got %0d want 9", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_lock();
    test_lock_reset();
    test_error_boundary();
    test_stale_ready();
    test_abort();
    test_watchdog();
`ifdef QLOOP_RELOCK_EN
    test_relock();
`endif
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL start_enable_overlap: got %0d want 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
